bus_transfer_sequencer: RTL and testbench

//  Sequences register-to-register moves over the shared 32-bit tri-state bus.

---
 rtl/bus_transfer_sequencer_if.sv | 35 +++
 rtl/bus_transfer_sequencer.sv | 120 ++++++++++++
 tb/tb_bus_transfer_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_transfer_sequencer_if.sv
// bus_transfer_sequencer_if: command handshake plus one-hot register-bus select/load signals.
// Build option BUS_XFER_COUNT_EN adds the 16-bit xfer_count transfer counter to the bundle.
interface bus_transfer_sequencer_if #(
    parameter int REGISTERS = 24,
    parameter int IDX_W     = 5
) ();
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [IDX_W-1:0]     cmd_src;
    logic [IDX_W-1:0]     cmd_dst;
    logic [REGISTERS-1:0] reg_out_sel;
    logic [REGISTERS-1:0] reg_in_en;
    logic                 busy;
    logic                 err_illegal;
`ifdef BUS_XFER_COUNT_EN
    logic [15:0]          xfer_count;
    modport master (
        output cmd_valid, cmd_src, cmd_dst,
        input  cmd_ready, reg_out_sel, reg_in_en, busy, err_illegal, xfer_count
    );
    modport slave (
        input  cmd_valid, cmd_src, cmd_dst,
        output cmd_ready, reg_out_sel, reg_in_en, busy, err_illegal, xfer_count
    );
`else
    modport master (
        output cmd_valid, cmd_src, cmd_dst,
        input  cmd_ready, reg_out_sel, reg_in_en, busy, err_illegal
    );
    modport slave (
        input  cmd_valid, cmd_src, cmd_dst,
        output cmd_ready, reg_out_sel, reg_in_en, busy, err_illegal
    );
`endif
endinterface

// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: queues (src,dst) moves and sequences one-hot bus driver/load selects.
// Build option BUS_XFER_COUNT_EN adds a wrapping 16-bit count of DRIVE cycles (xfer_count).
module bus_transfer_sequencer #(
    parameter int REGISTERS = 24,
    parameter int IDX_W     = 5,
    parameter int DEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    bus_transfer_sequencer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     src_mem [DEPTH];
    logic [IDX_W-1:0]     dst_mem [DEPTH];
    logic [PW:0]          wr_q, wr_d, rd_q, rd_d;
    logic [IDX_W-1:0]     cur_src_q, cur_src_d;
    logic [REGISTERS-1:0] sel_q, sel_d, en_q, en_d;
    logic                 ready_q, busy_q, err_q;
    logic                 empty, full_d, handshake, illegal, push, pop;
    logic [IDX_W-1:0]     head_src, head_dst;

    assign empty     = wr_q == rd_q;
    assign head_src  = src_mem[rd_q[PW-1:0]];
    assign head_dst  = dst_mem[rd_q[PW-1:0]];
    assign handshake = bus.cmd_valid & ready_q;
    assign illegal   = (32'(bus.cmd_src) >= REGISTERS) || (32'(bus.cmd_dst) >= REGISTERS)
                       || (bus.cmd_src == bus.cmd_dst);
    assign push      = handshake & ~illegal;
    assign wr_d      = wr_q + {{PW{1'b0}}, push};
    assign rd_d      = rd_q + {{PW{1'b0}}, pop};
    // fullness after this edge: pointers differ only in the wrap bit
    assign full_d    = (wr_d[PW] != rd_d[PW]) && (wr_d[PW-1:0] == rd_d[PW-1:0]);

    // command storage; entries need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            src_mem[wr_q[PW-1:0]] <= bus.cmd_src;
            dst_mem[wr_q[PW-1:0]] <= bus.cmd_dst;
        end
    end

    // next state plus registered select vectors; a pop always lands in DRIVE
    always_comb begin
        state_d   = state_q;
        cur_src_d = cur_src_q;
        pop       = 1'b0;
        sel_d     = '0;
        en_d      = '0;
        case (state_q)
            IDLE:    pop = !empty;
            DRIVE: begin
                pop     = !empty && head_src == cur_src_q;
                state_d = empty ? IDLE : TURN;
            end
            TURN: begin
                pop     = !empty;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            state_d   = DRIVE;
            cur_src_d = head_src;
            sel_d     = {{(REGISTERS-1){1'b0}}, 1'b1} << head_src;
            en_d      = {{(REGISTERS-1){1'b0}}, 1'b1} << head_dst;
        end
    end

    // all state and outputs are registered; reset aborts any transfer and empties the queue
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            cur_src_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            sel_q     <= '0;
            en_q      <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_src_q <= cur_src_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            ready_q   <= !full_d;
            busy_q    <= (state_d != IDLE) || (wr_d != rd_d);
            err_q     <= handshake & illegal;
        end
    end

    // one bus driver and one load target at most, in every cycle
    always_ff @(posedge clk) begin
        if (clr) assert ($onehot0(sel_q) && $onehot0(en_q));
    end

    assign bus.cmd_ready   = ready_q;
    assign bus.reg_out_sel = sel_q;
    assign bus.reg_in_en   = en_q;
    assign bus.busy        = busy_q;
    assign bus.err_illegal = err_q;

`ifdef BUS_XFER_COUNT_EN
    logic [15:0] cnt_q;

    // counts DRIVE cycles, registered together with the selects it counts
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) cnt_q <= '0;
        else      cnt_q <= cnt_q + {15'd0, state_d == DRIVE};
    end

    assign bus.xfer_count = cnt_q;
`endif
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb_bus_transfer_sequencer: directed table, corner sequences and random traffic vs a queue model.
// Honours BUS_XFER_COUNT_EN when the design is built with it.
module tb_bus_transfer_sequencer;
    localparam int REGS  = 24;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0] src;
        logic [4:0] dst;
    } cmd_t;

    typedef struct {
        logic        v;
        logic [4:0]  s;
        logic [4:0]  d;
        logic [23:0] sel;
        logic [23:0] en;
        logic        busy;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   errors = 0;
    cmd_t q[$];
    logic prev_drive;
    logic [4:0] prev_src;
    int   pushes, obs_drives;
    vec_t tbl[17];

    bus_transfer_sequencer_if #(.REGISTERS(REGS), .IDX_W(5)) bus ();

    bus_transfer_sequencer #(.REGISTERS(REGS), .IDX_W(5), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // one clock of traffic; expectations follow the queueing rules on the model queue
    task automatic step(input logic v, input logic [4:0] s, input logic [4:0] d);
        logic        hs, ill, exp_drive;
        logic [23:0] e_sel, e_en;
        cmd_t        head;
        bus.cmd_valid = v;
        bus.cmd_src   = s;
        bus.cmd_dst   = d;
        hs  = v && bus.cmd_ready;
        ill = (int'(s) >= REGS) || (int'(d) >= REGS) || (s == d);
        exp_drive = (q.size() != 0) ? (!prev_drive || q[0].src == prev_src) : 1'b0;
        @(posedge clk);
        #1;
        e_sel = '0;
        e_en  = '0;
        head  = '{src: 5'd0, dst: 5'd0};
        if (exp_drive) begin
            head = q.pop_front();
            e_sel[head.src] = 1'b1;
            e_en[head.dst]  = 1'b1;
        end
        if (hs && !ill) begin
            q.push_back('{src: s, dst: d});
            pushes++;
        end
        if (bus.reg_out_sel != '0) obs_drives++;
        chk("sel", bus.reg_out_sel, e_sel);
        chk("en", bus.reg_in_en, e_en);
        chk("err", bus.err_illegal, hs && ill);
        chk("busy", bus.busy, exp_drive || q.size() != 0);
        chk("ready", bus.cmd_ready, q.size() < DEPTH);
        prev_drive = exp_drive;
        prev_src   = head.src;
    endtask

    // async assert (possibly mid-transfer), hold with valid high, release between edges
    task automatic do_reset();
        bus.cmd_valid = 1'b1;
        bus.cmd_src   = 5'd3;
        bus.cmd_dst   = 5'd7;
        clr = 1'b0;
        #1;
        chk("rst_sel_async", bus.reg_out_sel, 0);
        chk("rst_en_async", bus.reg_in_en, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", bus.reg_out_sel, 0);
        chk("rst_en", bus.reg_in_en, 0);
        chk("rst_ready", bus.cmd_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err_illegal, 0);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ready", bus.cmd_ready, 1);
        chk("rel_busy", bus.busy, 0);
`ifdef BUS_XFER_COUNT_EN
        chk("rel_xfer_count", bus.xfer_count, 0);
`endif
        bus.cmd_valid = 1'b0;
        q.delete();
        prev_drive = 1'b0;
        prev_src   = '0;
        pushes     = 0;
        obs_drives = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((bus.busy || q.size() != 0) && n < 100) begin
            step(1'b0, 5'd0, 5'd0);
            n++;
        end
        chk({name, "_drained"}, q.size(), 0);
        chk({name, "_idle"}, bus.busy, 0);
        chk({name, "_moves"}, obs_drives, pushes);
`ifdef BUS_XFER_COUNT_EN
        chk({name, "_xfer_count"}, bus.xfer_count, pushes);
`endif
    endtask

    initial begin
        int   n, i;
        logic saw_full;
        bus.cmd_valid = 1'b0;
        bus.cmd_src   = '0;
        bus.cmd_dst   = '0;
        tbl[0]  = '{1'b1, 5'd3,  5'd7,  24'h0,  24'h0,  1'b1, 1'b0};
        tbl[1]  = '{1'b0, 5'd0,  5'd0,  24'h8,  24'h80, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 5'd0,  5'd0,  24'h0,  24'h0,  1'b0, 1'b0};
        tbl[3]  = '{1'b1, 5'd5,  5'd1,  24'h0,  24'h0,  1'b1, 1'b0};
        tbl[4]  = '{1'b1, 5'd5,  5'd2,  24'h20, 24'h2,  1'b1, 1'b0};
        tbl[5]  = '{1'b0, 5'd0,  5'd0,  24'h20, 24'h4,  1'b1, 1'b0};
        tbl[6]  = '{1'b0, 5'd0,  5'd0,  24'h0,  24'h0,  1'b0, 1'b0};
        tbl[7]  = '{1'b1, 5'd5,  5'd1,  24'h0,  24'h0,  1'b1, 1'b0};
        tbl[8]  = '{1'b1, 5'd6,  5'd2,  24'h20, 24'h2,  1'b1, 1'b0};
        tbl[9]  = '{1'b0, 5'd0,  5'd0,  24'h0,  24'h0,  1'b1, 1'b0};
        tbl[10] = '{1'b0, 5'd0,  5'd0,  24'h40, 24'h4,  1'b1, 1'b0};
        tbl[11] = '{1'b0, 5'd0,  5'd0,  24'h0,  24'h0,  1'b0, 1'b0};
        tbl[12] = '{1'b1, 5'd30, 5'd1,  24'h0,  24'h0,  1'b0, 1'b1};
        tbl[13] = '{1'b1, 5'd4,  5'd4,  24'h0,  24'h0,  1'b0, 1'b1};
        tbl[14] = '{1'b1, 5'd2,  5'd24, 24'h0,  24'h0,  1'b0, 1'b1};
        tbl[15] = '{1'b1, 5'd31, 5'd31, 24'h0,  24'h0,  1'b0, 1'b1};
        tbl[16] = '{1'b0, 5'd0,  5'd0,  24'h0,  24'h0,  1'b0, 1'b0};

        #1;
        do_reset();

        for (int k = 0; k < 17; k++) begin
            step(tbl[k].v, tbl[k].s, tbl[k].d);
            chk($sformatf("tbl%0d_sel", k), bus.reg_out_sel, tbl[k].sel);
            chk($sformatf("tbl%0d_en", k), bus.reg_in_en, tbl[k].en);
            chk($sformatf("tbl%0d_busy", k), bus.busy, tbl[k].busy);
            chk($sformatf("tbl%0d_err", k), bus.err_illegal, tbl[k].err);
        end
        drain("tbl");

        step(1'b1, 5'd5, 5'd1);
        step(1'b1, 5'd6, 5'd2);
        chk("mid_drive", bus.reg_out_sel, 24'h20);
        do_reset();
        step(1'b0, 5'd0, 5'd0);
        chk("mid_lost", bus.busy, 0);

        saw_full = 1'b0;
        i = 0;
        n = 0;
        while (i < 10 && n < 200) begin
            if (!bus.cmd_ready) saw_full = 1'b1;
            if (bus.cmd_ready) begin
                step(1'b1, (i % 2 == 0) ? 5'd8 : 5'd9, 5'(10 + i));
                i++;
            end else begin
                step(1'b1, (i % 2 == 0) ? 5'd8 : 5'd9, 5'(10 + i));
            end
            n++;
        end
        bus.cmd_valid = 1'b0;
        chk("fill_all_accepted", i, 10);
        chk("fill_saw_full", saw_full, 1);
        drain("fill");

        for (int k = 0; k < 400; k++) begin
            logic [4:0] s, d;
            s = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            d = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
            step($urandom_range(0, 3) != 0, s, d);
        end
        bus.cmd_valid = 1'b0;
        drain("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
